// File: rtl/box_filter_pkg.sv
// Shared definitions for box_filter / box_unfilter: default geometry,
// sample type and the window-sum width rule.
package box_filter_pkg;

  localparam int DEF_FILTER_SIZE = 4;
  localparam int DEF_DATA_WIDTH  = 32;

  typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

  // Worst-case window sum of n samples of w bits.
  function automatic int sum_width(int n, int w);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/box_history.sv
// FILTER_SIZE-deep circular sample buffer: read and write share one pointer
// that advances on every write and wraps explicitly at DEPTH-1.
module box_history
  import box_filter_pkg::*;
#(
  parameter int DEPTH = DEF_FILTER_SIZE,
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] hist;

  generate
    if (DEPTH == 1) begin : g_one
      // Single entry: no pointer needed.
      always_ff @(posedge clk) begin
        if (!rst || clear)  hist <= '0;
        else if (wr_en)     hist[0] <= wr_data;
      end
      assign rd_data = hist[0];
    end else begin : g_ring
      logic [PTR_W-1:0] wptr;

      always_ff @(posedge clk) begin
        if (!rst || clear) begin
          hist <= '0;
          wptr <= '0;
        end else if (wr_en) begin
          hist[wptr] <= wr_data;
          wptr       <= (wptr == PTR_W'(DEPTH-1)) ? '0 : wptr + 1'b1;
        end
      end
      assign rd_data = hist[wptr];
    end
  endgenerate

endmodule

// File: rtl/box_unfilter.sv
// Inverse box filter: x[n] = s[n] - s[n-1] + x[n-FILTER_SIZE], one cycle latency.
// Optional BOX_UNFILTER_COUNT_EN adds a saturating output-transfer counter port.
module box_unfilter
  import box_filter_pkg::*;
#(
  parameter  int FILTER_SIZE = DEF_FILTER_SIZE,
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  localparam int SUM_WIDTH   = sum_width(FILTER_SIZE, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SUM_WIDTH-1:0]  in,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef BOX_UNFILTER_COUNT_EN
  output logic [31:0]           count,
`endif
  output logic [DATA_WIDTH-1:0] out
);

  logic [SUM_WIDTH-1:0]  prev_sum;
  logic [DATA_WIDTH-1:0] hist_rd;
  logic [SUM_WIDTH-1:0]  t;
  logic                  accept;

  assign in_ready = rst && !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Modular arithmetic: wraparound cancels for any legal box-filter stream.
  assign t = in - prev_sum + SUM_WIDTH'(hist_rd);

  box_history #(
    .DEPTH (FILTER_SIZE),
    .WIDTH (DATA_WIDTH)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (accept),
    .wr_data (t[DATA_WIDTH-1:0]),
    .rd_data (hist_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      out_valid <= 1'b0;
      out       <= '0;
      prev_sum  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out       <= t[DATA_WIDTH-1:0];
      prev_sum  <= in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BOX_UNFILTER_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst || clear)
      count <= '0;
    else if (out_valid && out_ready && count != 32'hFFFF_FFFF)
      count <= count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_box_unfilter.sv
// Randomized bench for box_unfilter: drives box-filter window sums built from
// known samples and expects the samples back, one cycle after each accept.
module tb_box_unfilter;
  import box_filter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 34;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic [SW-1:0] in;
  logic [DW-1:0] out;
`ifdef BOX_UNFILTER_COUNT_EN
  logic [31:0]   count;
`endif

  always #5 clk = ~clk;

  box_unfilter #(.FILTER_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BOX_UNFILTER_COUNT_EN
    .count     (count),
`endif
    .out       (out)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: window of the last N original samples and expected outputs.
  logic [DW-1:0]   win[$];
  logic [DW-1:0]   exp_q[$];
  longint unsigned cnt_m = 0;
  int              mode  = 0;   // 0: out_ready=1, 1: random, 2: manual

  function automatic logic [SW-1:0] window_sum();
    logic [SW-1:0] s = '0;
    foreach (win[i]) s += SW'(win[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    #1;
    if (mode == 0)      out_ready = 1'b1;
    else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: sampled on the falling edge, checks the previous rising edge's effect.
  logic          p_flush = 1'b1, p_acc = 1'b0, p_hold = 1'b0;
  logic [DW-1:0] p_out   = '0;

  always @(negedge clk) begin
    check("in_ready", in_ready, rst && !clear && (!out_valid || out_ready));
    if (p_flush) begin
      check("flush_valid", out_valid, 0);
      check("flush_out", out, 0);
      exp_q.delete();
      cnt_m = 0;
    end else if (p_acc) begin
      check("latency", out_valid, 1);
    end
    if (p_hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_out", out, p_out);
    end
`ifdef BOX_UNFILTER_COUNT_EN
    check("count", count, cnt_m);
`endif
    if (out_valid && out_ready && rst && !clear) begin
      if (exp_q.size() == 0) check("unexpected_out", out, 64'hDEAD);
      else                   check("data", out, exp_q.pop_front());
      if (cnt_m != 32'hFFFF_FFFF) cnt_m++;
    end
    p_flush = !rst || clear;
    p_acc   = in_valid && in_ready;
    p_hold  = out_valid && !out_ready && rst && !clear;
    p_out   = out;
  end

  task automatic send_sum(input logic [SW-1:0] s, output bit ok);
    bit acc;
    ok       = 1'b0;
    in_valid = 1'b1;
    in       = s;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      ok = acc;
    end
    #1 in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_x(input logic [DW-1:0] x);
    bit ok;
    win.push_back(x);
    if (win.size() > N) void'(win.pop_front());
    send_sum(window_sum(), ok);
    if (ok) exp_q.push_back(x);
  endtask

  task automatic do_rst();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    win.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic: sums 1,3,6,10,14,18 -> 1..6
    for (int i = 1; i <= 6; i++) send_x(DW'(i));
    idle(3);
    do_rst(); idle(2);

    // Backpressure: stall the first output for 3 cycles
    mode = 2; out_ready = 1'b1;
    fork
      for (int i = 1; i <= 6; i++) send_x(DW'(i));
      begin
        for (int t = 0; t < 50 && !out_valid; t++) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    mode = 0; idle(3);
    do_rst(); idle(2);

    // Wrap: 12 random 16-bit samples
    for (int i = 0; i < 12; i++) send_x(DW'($urandom_range(0, 65535)));
    idle(3);
    do_rst(); idle(2);

    // Modular: all-ones four times then zero
    for (int i = 0; i < 4; i++) send_x(32'hFFFF_FFFF);
    send_x(32'h0);
    idle(3);
    do_rst(); idle(2);

    // Clear mid-stream with a competing input that must be dropped
    send_x(1); send_x(2); send_x(3);
    idle(2);
    clear = 1'b1; in_valid = 1'b1; in = SW'(100);
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    win.delete();
    send_x(7); send_x(8);
    idle(3);

    // Reset while an output is held
    mode = 2; out_ready = 1'b0;
    send_x(5);
    check("held_before_rst", out_valid, 1);
    do_rst();
    out_ready = 1'b1; mode = 0;
    idle(2);

    // Random long run with random backpressure
    mode = 1;
    for (int i = 0; i < 200; i++) send_x($urandom());
    mode = 0;
    idle(10);
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
